// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and digit moduli for the BCD stopwatch
package stopwatch_pkg;
  typedef enum logic [1:0] {STOPPED, RUNNING, LAP} sw_state_t;
  typedef logic [3:0] bcd_t;
  localparam int unsigned MOD_TEN = 10;
  localparam int unsigned MOD_SIX = 6;
endpackage

// File: rtl/stopwatch_bcd_digit_cnt.sv
// bcd_digit_cnt: one BCD digit counting modulo MOD
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (wins over inc)
//   inc        : advance by one, wrapping MOD-1 -> 0
//   q          : digit value
//   at_max     : q == MOD-1, used to build the carry chain
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter int unsigned MOD = MOD_TEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output bcd_t q,
  output logic at_max
);
  assign at_max = (q == bcd_t'(MOD - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (inc) q <= at_max ? '0 : q + 1'b1;
endmodule

// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: MM:SS.t BCD stopwatch with start/stop, clear and lap-freeze
//   clk, rst_n        : clock, async active-low reset
//   go, clr, lap      : single-cycle control pulses (priority clr > go > lap)
//   tenths..min_tens  : displayed BCD digits (lap latch while in LAP)
//   running           : high in RUNNING or LAP
//   wrap              : one-cycle pulse on 59:59.9 -> 00:00.0
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICKS_PER_TENTH = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go,
  input  logic clr,
  input  logic lap,
  output bcd_t tenths,
  output bcd_t sec_ones,
  output bcd_t sec_tens,
  output bcd_t min_ones,
  output bcd_t min_tens,
  output logic running,
  output logic wrap
);
  localparam int unsigned PW = $clog2(TICKS_PER_TENTH);
  sw_state_t state, state_n;
  logic [PW-1:0] pre;
  logic active, tick, cap, show;
  bcd_t q [5];
  bcd_t lat [5];
  logic mx [5];
  logic inc [5];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= STOPPED;
    else state <= state_n;
  always_comb begin
    state_n = state;
    cap = 1'b0;
    if (clr) state_n = STOPPED;
    else if (go) state_n = (state == STOPPED) ? RUNNING : STOPPED;
    else if (lap && state == RUNNING) begin
      state_n = LAP;
      cap = 1'b1;
    end else if (lap && state == LAP) state_n = RUNNING;
  end
  assign active = (state != STOPPED);
  assign running = active;
  assign show = (state == LAP);
  assign tick = active && (pre == PW'(TICKS_PER_TENTH - 1));
  // prescaler only advances while running, so a stop keeps the partial tenth
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pre <= '0;
    else if (clr) pre <= '0;
    else if (active) pre <= tick ? '0 : pre + 1'b1;
  // each digit advances on tick when every lower digit is at its maximum
  assign inc[0] = tick;
  genvar i;
  for (i = 0; i < 5; i++) begin : g_dig
    if (i > 0) begin : g_carry
      assign inc[i] = inc[i-1] & mx[i-1];
    end
    bcd_digit_cnt #(.MOD((i == 2 || i == 4) ? MOD_SIX : MOD_TEN)) u_dig (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .inc   (inc[i]),
      .q     (q[i]),
      .at_max(mx[i])
    );
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) lat[i] <= '0;
      else if (clr) lat[i] <= '0;
      else if (cap) lat[i] <= q[i];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wrap <= 1'b0;
    else wrap <= !clr && inc[4] && mx[4];
  assign tenths   = show ? lat[0] : q[0];
  assign sec_ones = show ? lat[1] : q[1];
  assign sec_tens = show ? lat[2] : q[2];
  assign min_ones = show ? lat[3] : q[3];
  assign min_tens = show ? lat[4] : q[4];
endmodule

// File: tb/tb_stopwatch_bcd.sv
// tb_stopwatch_bcd: directed self-checking bench for stopwatch_bcd
module tb_stopwatch_bcd;
  logic clk = 1'b0, rst_n = 1'b0, go = 1'b0, clr = 1'b0, lap = 1'b0, go2 = 1'b0;
  logic [3:0] tenths, sec_ones, sec_tens, min_ones, min_tens;
  logic [3:0] t2, so2, st2, mo2, mt2;
  logic running, wrap, running2, wrap2;
  logic [19:0] d, d2;
  logic [9:0] seen;
  int total = 0, bad = 0, edges = 0, w0 = 0;

  always #5 clk = ~clk;

  assign d  = {min_tens, min_ones, sec_tens, sec_ones, tenths};
  assign d2 = {mt2, mo2, st2, so2, t2};

  stopwatch_bcd #(.TICKS_PER_TENTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .clr(clr), .lap(lap),
    .tenths(tenths), .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens), .running(running), .wrap(wrap)
  );

  // fast instance so the full hour wrap fits in a short run
  stopwatch_bcd #(.TICKS_PER_TENTH(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .go(go2), .clr(1'b0), .lap(1'b0),
    .tenths(t2), .sec_ones(so2), .sec_tens(st2),
    .min_ones(mo2), .min_tens(mt2), .running(running2), .wrap(wrap2)
  );

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  initial begin
    step(2);
    chk("reset_digits", d, 20'h0);
    chk("reset_running", 20'(running), 20'h0);
    chk("reset_wrap", 20'(wrap), 20'h0);
    chk("reset_digits_w", d2, 20'h0);
    rst_n = 1'b1;
    step();
    go2 = 1'b1;
    step();
    go2 = 1'b0;
    w0 = edges;
    chk("w_running", 20'(running2), 20'h1);

    go = 1'b1; step(); go = 1'b0;
    chk("go_running", 20'(running), 20'h1);
    chk("go_digits", d, 20'h0);
    step(3);
    chk("pre_first_tick", d, 20'h0);
    step();
    chk("first_tick", d, 20'h1);
    seen = 10'b11;
    for (int i = 0; i < 36; i++) begin
      step();
      if (tenths < 4'd10) seen[tenths] = 1'b1;
      chk("bcd_range", 20'({tenths <= 4'd9, sec_ones <= 4'd9, sec_tens <= 4'd5,
                            min_ones <= 4'd9, min_tens <= 4'd5}), 20'h1f);
    end
    chk("one_second", d, 20'h00010);
    chk("tenths_visited", 20'(seen), 20'h003ff);

    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_digits", d, 20'h0);
    chk("clr_running", 20'(running), 20'h0);

    go = 1'b1; step(); go = 1'b0;
    step(5);
    go = 1'b1; step(); go = 1'b0;
    chk("stop_digits", d, 20'h1);
    chk("stop_running", 20'(running), 20'h0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("stop_hold", d, 20'h1);
    end
    go = 1'b1; step(); go = 1'b0;
    chk("resume_running", 20'(running), 20'h1);
    chk("resume_r0", d, 20'h1);
    step();
    chk("resume_r1", d, 20'h1);
    step();
    chk("resume_r2", d, 20'h2);

    clr = 1'b1; step(); clr = 1'b0;
    lap = 1'b1; step(); lap = 1'b0;
    chk("lap_stopped_running", 20'(running), 20'h0);
    step(4);
    chk("lap_stopped_digits", d, 20'h0);

    go = 1'b1; step(); go = 1'b0;
    step(92);
    chk("pre_lap", d, 20'h00023);
    lap = 1'b1; step(); lap = 1'b0;
    chk("lap_freeze", d, 20'h00023);
    chk("lap_running", 20'(running), 20'h1);
    for (int i = 0; i < 99; i++) begin
      step();
      chk("lap_hold", d, 20'h00023);
      chk("lap_hold_running", 20'(running), 20'h1);
    end
    lap = 1'b1; step(); lap = 1'b0;
    chk("lap_release", d, 20'h00048);
    chk("lap_release_running", 20'(running), 20'h1);

    clr = 1'b1; go = 1'b1; step(); clr = 1'b0; go = 1'b0;
    chk("clr_go_digits", d, 20'h0);
    chk("clr_go_running", 20'(running), 20'h0);
    step(3);
    chk("clr_go_hold", d, 20'h0);

    go = 1'b1; step(); go = 1'b0;
    step(4);
    chk("pre_go_lap", d, 20'h1);
    go = 1'b1; lap = 1'b1; step(); go = 1'b0; lap = 1'b0;
    chk("go_lap_running", 20'(running), 20'h0);
    chk("go_lap_digits", d, 20'h1);
    step(8);
    chk("go_lap_hold", d, 20'h1);
    chk("go_lap_stopped", 20'(running), 20'h0);

    go = 1'b1; step(); go = 1'b0;
    lap = 1'b1; step(); lap = 1'b0;
    step(8);
    chk("lap_latched", d, 20'h1);
    go = 1'b1; step(); go = 1'b0;
    chk("lap_stop_live", d, 20'h3);
    chk("lap_stop_running", 20'(running), 20'h0);

    while (edges < w0 + 71996) step();
    chk("w_5959_8", d2, 20'h59598);
    chk("w_no_early_wrap", 20'(wrap2), 20'h0);
    step(2);
    chk("w_5959_9", d2, 20'h59599);
    step();
    chk("w_hold_9", d2, 20'h59599);
    chk("w_wrap_low", 20'(wrap2), 20'h0);
    step();
    chk("w_rollover", d2, 20'h0);
    chk("w_wrap_pulse", 20'(wrap2), 20'h1);
    chk("w_still_running", 20'(running2), 20'h1);
    step();
    chk("w_wrap_one_cycle", 20'(wrap2), 20'h0);
    chk("w_after", d2, 20'h0);

    go = 1'b1; step(); go = 1'b0;
    step(13);
    chk("pre_reset_nonzero", 20'(d != 20'h0), 20'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_digits", d, 20'h0);
    chk("async_running", 20'(running), 20'h0);
    chk("async_wrap", 20'(wrap), 20'h0);
    chk("async_digits_w", d2, 20'h0);
    chk("async_running_w", 20'(running2), 20'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
